sdram_model: RTL and testbench



---
 rtl/sdram_model_if.sv | 26 ++
 rtl/sdram_model.sv | 243 ++++++++++++++++++++++++
 tb/tb_sdram_model.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_model_if.sv
// Command/data bus between the SDRAM controller (master) and the chip model (slave).
// sd_data_oe exposes the model's per-byte drive enables so the bus state is observable.
interface sdram_model_if;
    logic        sd_cke;
    logic        sd_cs;
    logic        sd_ras;
    logic        sd_cas;
    logic        sd_we;
    logic [1:0]  sd_ba;
    logic [10:0] sd_addr;
    logic [3:0]  sd_dqm;
    wire  [31:0] sd_data;
    logic [3:0]  sd_data_oe;

    modport master (
        output sd_cke, sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm,
        inout  sd_data,
        input  sd_data_oe
    );

    modport slave (
        input  sd_cke, sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm,
        inout  sd_data,
        output sd_data_oe
    );
endinterface

// File: rtl/sdram_model.sv
// Synthesizable single-chip 32-bit SDRAM responder: bank tracking, byte-masked storage, CL read slots.
// Protocol-violation detection is compiled in only when SDRAM_MODEL_CHECK_EN is defined.
module sdram_model #(
    parameter int MEM_AW = 21,
    parameter int RCD    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    sdram_model_if.slave sd,
    output logic         ready,
    output logic         err,
    output logic [2:0]   err_code,
    output logic [15:0]  ref_cnt
);
    typedef enum logic [2:0] {
        CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_e;

    cmd_e              w_cmd;
    logic [1:0]        w_ba;
    logic              w_a10;
    logic [10:0]       w_row;
    logic [20:0]       w_idx_full;
    logic [MEM_AW-1:0] w_idx;
    logic              w_access;
    logic              w_mode_ok;
    logic [1:0]        w_ins;
    logic [3:0]        w_oe;

    logic [3:0]        r_open;
    logic [10:0]       r_row [4];
    logic [2:0]        r_cl;
    logic              r_ready;
    logic [15:0]       r_ref_cnt;
    logic [2:0]        r_slot_v;
    logic [31:0]       r_slot_d [3];
    logic [3:0]        r_slot_m [3];
    logic [31:0]       r_mem [2**MEM_AW];

    // Slot index so that a READ reaches slot 0 (the drive slot) after CL-1 shifts.
    function automatic logic [1:0] slot_index(input logic [2:0] cl);
        logic [1:0] idx;
        case (cl)
            3'd0, 3'd1: idx = 2'd0;
            3'd2:       idx = 2'd1;
            default:    idx = 2'd2;
        endcase
        return idx;
    endfunction

    assign w_cmd      = (sd.sd_cke && !sd.sd_cs) ? cmd_e'({sd.sd_ras, sd.sd_cas, sd.sd_we}) : CMD_NOP;
    assign w_ba       = sd.sd_ba;
    assign w_a10      = sd.sd_addr[10];
    assign w_row      = r_open[w_ba] ? r_row[w_ba] : 11'd0;
    assign w_idx_full = {w_ba, w_row, sd.sd_addr[7:0]};
    assign w_idx      = w_idx_full[MEM_AW-1:0];
    assign w_ins      = slot_index(r_cl);
    assign w_oe       = {4{r_slot_v[0]}} & ~r_slot_m[0];

`ifdef SDRAM_MODEL_CHECK_EN
    localparam logic [2:0] RCD_AGE = 3'(RCD);

    logic [2:0] r_age [4];
    logic       w_err_hit;
    logic [2:0] w_err_new;
    logic       r_err;
    logic [2:0] r_err_code;

    // Command legality: decides whether an access executes and which error it raises.
    always_comb begin
        w_access  = 1'b0;
        w_mode_ok = 1'b0;
        w_err_hit = 1'b0;
        w_err_new = 3'd0;
        case (w_cmd)
            CMD_LMR: begin
                w_mode_ok = ((sd.sd_addr[6:4] == 3'd2) || (sd.sd_addr[6:4] == 3'd3)) &&
                            (sd.sd_addr[2:0] == 3'd0);
                if (!w_mode_ok || (|r_open)) begin
                    w_err_hit = 1'b1;
                    w_err_new = 3'd6;
                end else begin
                    w_err_hit = 1'b0;
                end
            end
            CMD_ACT: begin
                if (r_open[w_ba]) begin
                    w_err_hit = 1'b1;
                    w_err_new = 3'd2;
                end else begin
                    w_err_hit = 1'b0;
                end
            end
            CMD_RD, CMD_WR: begin
                if (!r_ready) begin
                    w_err_hit = 1'b1;
                    w_err_new = 3'd1;
                end else if (!r_open[w_ba]) begin
                    w_err_hit = 1'b1;
                    w_err_new = 3'd3;
                end else begin
                    // A tRCD violation is still executed; only the flag is raised.
                    w_access = 1'b1;
                    if (r_age[w_ba] < RCD_AGE) begin
                        w_err_hit = 1'b1;
                        w_err_new = 3'd4;
                    end else if ((w_cmd == CMD_WR) && r_slot_v[0]) begin
                        w_err_hit = 1'b1;
                        w_err_new = 3'd7;
                    end else begin
                        w_err_hit = 1'b0;
                    end
                end
            end
            CMD_REF: begin
                if (|r_open) begin
                    w_err_hit = 1'b1;
                    w_err_new = 3'd5;
                end else begin
                    w_err_hit = 1'b0;
                end
            end
            default: w_err_hit = 1'b0;
        endcase
    end

    // Per-bank age holds the value the bank will have at the next edge, saturating at 7.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 4; b++) r_age[b] <= 3'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if ((w_cmd == CMD_ACT) && (w_ba == 2'(b))) r_age[b] <= 3'd1;
                else if (r_age[b] != 3'd7)                 r_age[b] <= r_age[b] + 3'd1;
                else                                       r_age[b] <= r_age[b];
            end
        end
    end

    // Sticky first-error capture followed by the registered error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
            err        <= 1'b0;
            err_code   <= 3'd0;
        end else begin
            if (w_err_hit && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_new;
            end
            err      <= r_err;
            err_code <= r_err_code;
        end
    end
`else
    // Without checking every access executes; idle banks fall back to row 0.
    always_comb begin
        w_access  = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
        w_mode_ok = (w_cmd == CMD_LMR);
    end

    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

    // Bank state, mode register, refresh counter and the read-data slot pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_open    <= 4'd0;
            r_cl      <= 3'd2;
            r_ready   <= 1'b0;
            r_ref_cnt <= 16'd0;
            r_slot_v  <= 3'd0;
            for (int b = 0; b < 4; b++) r_row[b] <= 11'd0;
            for (int s = 0; s < 3; s++) begin
                r_slot_d[s] <= 32'd0;
                r_slot_m[s] <= 4'd0;
            end
        end else begin
            r_slot_v    <= {1'b0, r_slot_v[2:1]};
            r_slot_d[0] <= r_slot_d[1];
            r_slot_d[1] <= r_slot_d[2];
            r_slot_m[0] <= r_slot_m[1];
            r_slot_m[1] <= r_slot_m[2];
            case (w_cmd)
                CMD_LMR: begin
                    if (w_mode_ok) begin
                        r_cl    <= sd.sd_addr[6:4];
                        r_ready <= 1'b1;
                    end
                end
                CMD_ACT: begin
                    r_open[w_ba] <= 1'b1;
                    r_row[w_ba]  <= sd.sd_addr;
                end
                CMD_RD: begin
                    if (w_access) begin
                        r_slot_v[w_ins] <= 1'b1;
                        r_slot_d[w_ins] <= r_mem[w_idx];
                        r_slot_m[w_ins] <= sd.sd_dqm;
                        if (w_a10) r_open[w_ba] <= 1'b0;
                    end
                end
                CMD_WR: begin
                    if (w_access && w_a10) r_open[w_ba] <= 1'b0;
                end
                CMD_PRE: begin
                    if (w_a10) r_open <= 4'd0;
                    else       r_open[w_ba] <= 1'b0;
                end
                CMD_REF: r_ref_cnt <= r_ref_cnt + 16'd1;
                default: r_ref_cnt <= r_ref_cnt;
            endcase
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready   <= 1'b0;
            ref_cnt <= 16'd0;
        end else begin
            ready   <= r_ready;
            ref_cnt <= r_ref_cnt;
        end
    end

    // Backing store sits outside reset so its contents survive it; bytes with dqm=1 keep old data.
    always_ff @(posedge clk) begin
        if ((w_cmd == CMD_WR) && w_access) begin
            for (int i = 0; i < 4; i++) begin
                if (!sd.sd_dqm[i]) r_mem[w_idx][8*i +: 8] <= sd.sd_data[8*i +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_dq
        assign sd.sd_data[8*gi +: 8] = w_oe[gi] ? r_slot_d[0][8*gi +: 8] : 8'hzz;
    end
    assign sd.sd_data_oe = w_oe;
endmodule

// File: tb/tb_sdram_model.sv
// Directed self-checking bench for sdram_model; error expectations follow SDRAM_MODEL_CHECK_EN.
module tb_sdram_model;
`ifdef SDRAM_MODEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        clk;
    logic        reset_n;
    logic        ready;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] ref_cnt;
    logic        tb_drv;
    logic [31:0] tb_wdata;
    int          n_tests;
    int          n_fail;

    sdram_model_if bus ();

    assign bus.sd_data = tb_drv ? tb_wdata : 32'hzzzz_zzzz;

    sdram_model dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sd       (bus),
        .ready    (ready),
        .err      (err),
        .err_code (err_code),
        .ref_cnt  (ref_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: the command set here is sampled at the following rising edge.
    task automatic tick(input logic [2:0] cmd, input logic [1:0] ba, input logic [10:0] addr,
                        input logic [3:0] dqm, input logic [31:0] wd);
        @(negedge clk);
        bus.sd_cke = 1'b1;
        bus.sd_cs  = 1'b0;
        {bus.sd_ras, bus.sd_cas, bus.sd_we} = cmd;
        bus.sd_ba   = ba;
        bus.sd_addr = addr;
        bus.sd_dqm  = dqm;
        tb_drv      = (cmd == C_WR);
        tb_wdata    = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(C_NOP, 2'd0, 11'd0, 4'd0, 32'd0);
    endtask

    task automatic apply_reset();
        idle(1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        tb_drv      = 1'b0;
        tb_wdata    = 32'd0;
        bus.sd_cke  = 1'b1;
        bus.sd_cs   = 1'b1;
        {bus.sd_ras, bus.sd_cas, bus.sd_we} = C_NOP;
        bus.sd_ba   = 2'd0;
        bus.sd_addr = 11'd0;
        bus.sd_dqm  = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(ready),          32'd0);
        check("rst_err",    32'(err),            32'd0);
        check("rst_code",   32'(err_code),       32'd0);
        check("rst_refcnt", 32'(ref_cnt),        32'd0);
        check("rst_oe",     32'(bus.sd_data_oe), 32'd0);
        reset_n = 1'b1;

        // CL=2 write with auto-precharge, re-open, read back.
        tick(C_LMR, 2'd0, 11'h220, 4'h0, 32'd0);
        idle(3);
        check("mode_ready", 32'(ready), 32'd1);
        tick(C_ACT, 2'd1, 11'h155, 4'h0, 32'd0);
        idle(1);
        tick(C_WR,  2'd1, 11'h412, 4'h0, 32'hDEADBEEF);
        tick(C_ACT, 2'd1, 11'h155, 4'h0, 32'd0);
        idle(1);
        tick(C_RD,  2'd1, 11'h012, 4'h0, 32'd0);
        idle(1);
        check("cl2_before_oe", 32'(bus.sd_data_oe), 32'h0);
        idle(1);
        check("cl2_slot_oe",   32'(bus.sd_data_oe), 32'hF);
        check("cl2_slot_data", bus.sd_data,          32'hDEADBEEF);
        idle(1);
        check("cl2_after_oe",  32'(bus.sd_data_oe), 32'h0);

        // Byte masks on write and read, back-to-back reads.
        tick(C_WR, 2'd1, 11'h020, 4'b0000, 32'h11223344);
        tick(C_WR, 2'd1, 11'h020, 4'b1100, 32'hAABBCCDD);
        tick(C_RD, 2'd1, 11'h020, 4'b0000, 32'd0);
        tick(C_RD, 2'd1, 11'h020, 4'b0011, 32'd0);
        idle(1);
        check("b2b_first_oe",   32'(bus.sd_data_oe), 32'hF);
        check("b2b_first_data", bus.sd_data,          32'h1122CCDD);
        idle(1);
        check("b2b_mask_oe",    32'(bus.sd_data_oe), 32'hC);
        check("b2b_mask_hi",    32'(bus.sd_data[31:16]), 32'h1122);
        idle(1);
        check("b2b_after_oe",   32'(bus.sd_data_oe), 32'h0);
        check("clean_err",      32'(err),            32'd0);

        // CL=3 shifts the data slot one cycle later.
        tick(C_PRE, 2'd0, 11'h400, 4'h0, 32'd0);
        tick(C_LMR, 2'd0, 11'h230, 4'h0, 32'd0);
        tick(C_ACT, 2'd1, 11'h155, 4'h0, 32'd0);
        idle(1);
        tick(C_RD,  2'd1, 11'h012, 4'h0, 32'd0);
        idle(2);
        check("cl3_early_oe", 32'(bus.sd_data_oe), 32'h0);
        idle(1);
        check("cl3_slot_oe",   32'(bus.sd_data_oe), 32'hF);
        check("cl3_slot_data", bus.sd_data,          32'hDEADBEEF);
        idle(1);
        check("cl3_after_oe",  32'(bus.sd_data_oe), 32'h0);
        check("cl3_err",       32'(err),            32'd0);

        // Illegal burst length.
        apply_reset();
        tick(C_LMR, 2'd0, 11'h221, 4'h0, 32'd0);
        idle(3);
        check("badmode_code",  32'(err_code), CHK ? 32'd6 : 32'd0);
        check("badmode_ready", 32'(ready),    CHK ? 32'd0 : 32'd1);

        // tRCD violation, then ACT to an open bank must not overwrite the code.
        apply_reset();
        tick(C_LMR, 2'd0, 11'h220, 4'h0, 32'd0);
        tick(C_ACT, 2'd0, 11'h003, 4'h0, 32'd0);
        tick(C_RD,  2'd0, 11'h000, 4'h0, 32'd0);
        idle(3);
        check("trcd_code", 32'(err_code), CHK ? 32'd4 : 32'd0);
        tick(C_ACT, 2'd0, 11'h003, 4'h0, 32'd0);
        idle(3);
        check("sticky_err",  32'(err),      CHK ? 32'd1 : 32'd0);
        check("sticky_code", 32'(err_code), CHK ? 32'd4 : 32'd0);

        // Refresh counting and refresh with an open bank.
        apply_reset();
        tick(C_LMR, 2'd0, 11'h220, 4'h0, 32'd0);
        for (int i = 0; i < 3; i++) tick(C_REF, 2'd0, 11'd0, 4'h0, 32'd0);
        idle(3);
        check("ref_cnt3",  32'(ref_cnt), 32'd3);
        check("ref_clean", 32'(err),     32'd0);
        tick(C_ACT, 2'd2, 11'h010, 4'h0, 32'd0);
        idle(1);
        tick(C_REF, 2'd0, 11'd0, 4'h0, 32'd0);
        idle(3);
        check("ref_cnt4",      32'(ref_cnt),  32'd4);
        check("ref_open_code", 32'(err_code), CHK ? 32'd5 : 32'd0);

        // Reset during a read data slot; memory survives reset.
        apply_reset();
        tick(C_LMR, 2'd0, 11'h220, 4'h0, 32'd0);
        tick(C_ACT, 2'd1, 11'h155, 4'h0, 32'd0);
        idle(1);
        tick(C_RD,  2'd1, 11'h012, 4'h0, 32'd0);
        idle(2);
        check("midrd_oe",    32'(bus.sd_data_oe), 32'hF);
        check("midrd_ready", 32'(ready),          32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_oe",    32'(bus.sd_data_oe), 32'h0);
        check("async_rst_ready", 32'(ready),          32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(C_LMR, 2'd0, 11'h220, 4'h0, 32'd0);
        tick(C_ACT, 2'd1, 11'h155, 4'h0, 32'd0);
        idle(1);
        tick(C_RD,  2'd1, 11'h020, 4'h0, 32'd0);
        idle(2);
        check("persist_oe",   32'(bus.sd_data_oe), 32'hF);
        check("persist_data", bus.sd_data,          32'h1122CCDD);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
